// File: rtl/ddr3_wr_pkg.sv
// Shared definitions for the DDR3 write-side pixel packer: FSM state
// encoding and the fixed sizes of the controller write interface.
package ddr3_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } wr_state_t;

    localparam int BYTES_PER_BEAT = 8;
    localparam int REQ_LEN_W      = 8;
    localparam int BEAT_CNT_W     = 7;

endpackage

// File: rtl/ddr3_wr_word_fifo.sv
// Single-clock show-ahead word FIFO. The head word is always visible on
// o_head; a push into a full FIFO is ignored unless a pop frees the slot
// in the same cycle.
module ddr3_wr_word_fifo #(
    parameter int DATA_W  = 64,
    parameter int DEPTH_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [DATA_W-1:0]  i_push_data,
    input  logic               i_pop,
    output logic [DATA_W-1:0]  o_head,
    output logic               o_full,
    output logic [DEPTH_W:0]   o_count
);

    localparam logic [DEPTH_W:0] FULL_COUNT = {1'b1, {DEPTH_W{1'b0}}};

    logic [DATA_W-1:0]  r_mem [0:(1<<DEPTH_W)-1];
    logic [DEPTH_W-1:0] r_wr_ptr;
    logic [DEPTH_W-1:0] r_rd_ptr;
    logic [DEPTH_W:0]   r_count;

    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_COUNT);
    assign w_pop_ok  = i_pop & ~w_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (DEPTH_W+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ddr3_ov5640_wr_packer.sv
// Packs 16-bit camera pixels into 64-bit DDR3 words, buffers them, and
// issues fixed-length burst writes at linear, frame-wrapping addresses.
module ddr3_ov5640_wr_packer
    import ddr3_wr_pkg::*;
#(
    parameter int                    IN_DATA_WIDTH  = 16,
    parameter int                    OUT_DATA_WIDTH = 64,
    parameter int                    BURST_LEN      = 16,
    parameter int                    FIFO_DEPTH_W   = 6,
    parameter int                    ADDR_WIDTH     = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           FRAME_BYTES    = 1280*720*2
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic                      frame_start,
    input  logic                      pix_en,
    input  logic [IN_DATA_WIDTH-1:0]  pix_data,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [ADDR_WIDTH-1:0]     req_addr,
    output logic [REQ_LEN_W-1:0]      req_len,
    output logic                      wdata_valid,
    input  logic                      wdata_ready,
    output logic [OUT_DATA_WIDTH-1:0] wdata,
    output logic                      wdata_last,
    output logic                      overflow
);

    localparam int LANES  = OUT_DATA_WIDTH / IN_DATA_WIDTH;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [LANE_W-1:0]         LAST_LANE   = LANE_W'(LANES-1);
    localparam logic [FIFO_DEPTH_W:0]     BURST_WORDS = (FIFO_DEPTH_W+1)'(BURST_LEN);
    localparam logic [BEAT_CNT_W-1:0]     LAST_BEAT   = BEAT_CNT_W'(BURST_LEN-1);
    localparam logic [ADDR_WIDTH-1:0]     BURST_BYTES = ADDR_WIDTH'(BURST_LEN*BYTES_PER_BEAT);
    localparam logic [ADDR_WIDTH-1:0]     FRAME_END   = BASE_ADDR + ADDR_WIDTH'(FRAME_BYTES);

    logic [LANE_W-1:0]         r_lane;
    logic [OUT_DATA_WIDTH-1:0] r_pack;
    logic                      r_push;
    logic [OUT_DATA_WIDTH-1:0] r_push_word;
    logic                      r_overflow;

    wr_state_t                 r_state;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_addr_pend;
    logic                      r_req_valid;
    logic [ADDR_WIDTH-1:0]     r_req_addr;
    logic                      r_wdata_valid;
    logic                      r_wdata_last;
    logic [BEAT_CNT_W-1:0]     r_beat_cnt;

    logic [LANE_W-1:0]         w_lane;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_drop;
    logic [FIFO_DEPTH_W:0]     w_count;
    logic [OUT_DATA_WIDTH-1:0] w_head;
    logic [ADDR_WIDTH-1:0]     w_idle_addr;
    logic [ADDR_WIDTH-1:0]     w_addr_inc;
    logic [ADDR_WIDTH-1:0]     w_next_addr;

    // A frame start restarts packing at lane 0 in the very same cycle.
    assign w_lane      = frame_start ? '0 : r_lane;
    assign w_pop       = r_wdata_valid & wdata_ready;
    assign w_drop      = r_push & w_full & ~w_pop;
    assign w_idle_addr = r_addr_pend ? BASE_ADDR : r_addr;
    assign w_addr_inc  = r_addr + BURST_BYTES;
    assign w_next_addr = (w_addr_inc == FRAME_END) ? BASE_ADDR : w_addr_inc;

    assign req_valid   = r_req_valid;
    assign req_addr    = r_req_addr;
    assign req_len     = REQ_LEN_W'(BURST_LEN-1);
    assign wdata_valid = r_wdata_valid;
    assign wdata_last  = r_wdata_last;
    assign wdata       = r_wdata_valid ? w_head : '0;
    assign overflow    = r_overflow;

    ddr3_wr_word_fifo #(
        .DATA_W  (OUT_DATA_WIDTH),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_fifo (
        .i_clk       (wr_clk),
        .i_rst       (wr_rst),
        .i_push      (r_push),
        .i_push_data (r_push_word),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_count     (w_count)
    );

    // Pixel packer: collects lanes and hands a finished word to the FIFO one cycle later.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_lane      <= '0;
            r_pack      <= '0;
            r_push      <= 1'b0;
            r_push_word <= '0;
        end else begin
            r_push <= 1'b0;
            if (pix_en) begin
                r_pack[w_lane*IN_DATA_WIDTH +: IN_DATA_WIDTH] <= pix_data;
                if (w_lane == LAST_LANE) begin
                    r_push      <= 1'b1;
                    r_push_word <= {pix_data, r_pack[OUT_DATA_WIDTH-IN_DATA_WIDTH-1:0]};
                    r_lane      <= '0;
                end else begin
                    r_lane <= w_lane + LANE_W'(1);
                end
            end else if (frame_start) begin
                r_lane <= '0;
            end
        end
    end

    // Sticky drop flag; a new drop in the frame-start cycle still wins.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (frame_start) begin
            r_overflow <= 1'b0;
        end
    end

    // Burst FSM: address reload only between bursts, request, then stream beats.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= BASE_ADDR;
            r_addr_pend   <= 1'b0;
            r_req_valid   <= 1'b0;
            r_req_addr    <= '0;
            r_wdata_valid <= 1'b0;
            r_wdata_last  <= 1'b0;
            r_beat_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_addr_pend) begin
                        r_addr      <= BASE_ADDR;
                        r_addr_pend <= 1'b0;
                    end
                    if (w_count >= BURST_WORDS) begin
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= w_idle_addr;
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        r_state       <= ST_DATA;
                        r_req_valid   <= 1'b0;
                        r_wdata_valid <= 1'b1;
                        r_wdata_last  <= 1'b0;
                        r_beat_cnt    <= '0;
                    end
                end
                ST_DATA: begin
                    if (wdata_ready) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                        if (r_wdata_last) begin
                            r_state       <= ST_IDLE;
                            r_wdata_valid <= 1'b0;
                            r_wdata_last  <= 1'b0;
                            r_addr        <= w_next_addr;
                        end else begin
                            r_wdata_last <= ((r_beat_cnt + BEAT_CNT_W'(1)) == LAST_BEAT);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            if (frame_start) begin
                r_addr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_ov5640_wr_packer.sv
// Self-checking bench for ddr3_ov5640_wr_packer with a pixel-level
// reference model and in-order scoreboards for requests and beats.
module tb_ddr3_ov5640_wr_packer;

    localparam int          BURST = 16;
    localparam int          FB    = 1024;
    localparam logic [27:0] BASE  = 28'h0;

    logic        wr_clk = 1'b0;
    logic        wr_rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_en = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [27:0] req_addr;
    logic [7:0]  req_len;
    logic        wdata_valid;
    logic        wdata_ready = 1'b1;
    logic [63:0] wdata;
    logic        wdata_last;
    logic        overflow;

    int vecCount = 0;
    int missCount = 0;

    logic [63:0] expWords[$];
    logic [27:0] expAddr[$];
    logic [63:0] obsBeat[$];
    logic        obsLast[$];
    logic [27:0] obsAddr[$];

    int          mLane = 0;
    int          mPending = 0;
    int          mBurstIdx = 0;
    int          beatIdx = 0;
    logic [63:0] mWord = 64'h0;

    ddr3_ov5640_wr_packer #(
        .FRAME_BYTES (FB)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .pix_data    (pix_data),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .wdata_last  (wdata_last),
        .overflow    (overflow)
    );

    // Free-running clock, 10 ns period.
    always #5 wr_clk = ~wr_clk;

    // Record every accepted request and beat, sampled mid-cycle.
    always @(negedge wr_clk) begin
        if (!wr_rst) begin
            if (req_valid && req_ready) begin
                obsAddr.push_back(req_addr);
            end
            if (wdata_valid && wdata_ready) begin
                obsBeat.push_back(wdata);
                obsLast.push_back(wdata_last);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        vecCount++;
        assert (got === want) else begin
            missCount++;
            $error("[TB] FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Drive one cycle of pixel inputs and advance the reference model.
    task automatic applyStimulus(input logic en, input logic [15:0] pix, input logic fs);
        @(posedge wr_clk);
        #1;
        pix_en      = en;
        pix_data    = pix;
        frame_start = fs;
        if (fs) begin
            mLane     = 0;
            mBurstIdx = 0;
        end
        if (en) begin
            mWord[16*mLane +: 16] = pix;
            mLane++;
            if (mLane == 4) begin
                mLane = 0;
                expWords.push_back(mWord);
                mPending++;
                if (mPending == BURST) begin
                    expAddr.push_back(BASE + 28'((mBurstIdx * BURST * 8) % FB));
                    mBurstIdx++;
                    mPending = 0;
                end
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic waitBeats(input int n);
        int c;
        c = 0;
        while (obsBeat.size() < n && c < 3000) begin
            applyStimulus(1'b0, 16'h0, 1'b0);
            c++;
        end
        vecCount++;
        assert (obsBeat.size() >= n) else begin
            missCount++;
            $error("[TB] FAIL waitBeats got %0d want %0d", obsBeat.size(), n);
        end
    endtask

    // Compare everything observed so far against the model, in order.
    task automatic scoreboard();
        logic [63:0] d;
        logic        l;
        logic [27:0] a;
        while (obsBeat.size() > 0) begin
            d = obsBeat.pop_front();
            l = obsLast.pop_front();
            if (expWords.size() > 0) begin
                checkOutput("beatData", d, expWords.pop_front());
            end else begin
                checkOutput("beatData", d, 64'hx);
            end
            checkOutput("beatLast", {63'h0, l}, {63'h0, (beatIdx % BURST) == BURST-1});
            beatIdx++;
        end
        while (obsAddr.size() > 0) begin
            a = obsAddr.pop_front();
            if (expAddr.size() > 0) begin
                checkOutput("reqAddr", {36'h0, a}, {36'h0, expAddr.pop_front()});
            end else begin
                checkOutput("reqAddr", {36'h0, a}, 64'hx);
            end
        end
    endtask

    task automatic sendPixels(input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, first + 16'(i), 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        int          sent;
        int          c;
        logic        en;
        logic        seen;
        logic [27:0] holdAddr;

        // Reset state.
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        checkOutput("rstReqValid", {63'h0, req_valid}, 64'h0);
        checkOutput("rstReqAddr", {36'h0, req_addr}, 64'h0);
        checkOutput("rstWdValid", {63'h0, wdata_valid}, 64'h0);
        checkOutput("rstWdata", wdata, 64'h0);
        checkOutput("rstLast", {63'h0, wdata_last}, 64'h0);
        checkOutput("rstOvf", {63'h0, overflow}, 64'h0);
        checkOutput("reqLen", {56'h0, req_len}, 64'd15);
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b0;

        // Pixels 1..64, always ready: one burst at address 0.
        sendPixels(64, 16'h0001);
        waitBeats(16);
        checkOutput("beat0", obsBeat[0], 64'h0004_0003_0002_0001);
        scoreboard();

        // Request stalled by req_ready low.
        req_ready = 1'b0;
        sendPixels(64, 16'h0041);
        seen = 1'b0;
        c = 0;
        while (!seen && c < 200) begin
            tick(1);
            @(negedge wr_clk);
            seen = req_valid;
            c++;
        end
        checkOutput("stallReqSeen", {63'h0, seen}, 64'h1);
        holdAddr = BASE + 28'(BURST * 8);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            @(negedge wr_clk);
            checkOutput("stallValid", {63'h0, req_valid}, 64'h1);
            checkOutput("stallAddr", {36'h0, req_addr}, {36'h0, holdAddr});
            checkOutput("stallNoBeat", {63'h0, wdata_valid}, 64'h0);
        end
        req_ready = 1'b1;
        waitBeats(16);
        scoreboard();

        // Random pixel gaps and random back-pressure across a frame wrap.
        sent = 0;
        while (sent < 512) begin
            en = ($urandom_range(0, 3) != 0);
            applyStimulus(en, 16'($urandom), 1'b0);
            req_ready   = ($urandom_range(0, 2) != 0);
            wdata_ready = ($urandom_range(0, 2) != 0);
            if (en) sent++;
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
        req_ready   = 1'b1;
        wdata_ready = 1'b1;
        waitBeats(128);
        scoreboard();
        checkOutput("randNoOvf", {63'h0, overflow}, 64'h0);

        // frame_start in the middle of a burst.
        sendPixels(64, 16'h1000);
        seen = 1'b0;
        c = 0;
        while (!seen && c < 200) begin
            tick(1);
            @(negedge wr_clk);
            seen = wdata_valid;
            c++;
        end
        checkOutput("fsInData", {63'h0, seen}, 64'h1);
        applyStimulus(1'b1, 16'hBEEF, 1'b0);
        applyStimulus(1'b1, 16'hBEF0, 1'b0);
        applyStimulus(1'b1, 16'h2000, 1'b1);
        for (int i = 1; i < 64; i++) begin
            applyStimulus(1'b1, 16'h2000 + 16'(i), 1'b0);
        end
        applyStimulus(1'b0, 16'h0, 1'b0);
        waitBeats(32);
        scoreboard();

        // Overflow: 65 words with wdata_ready held low.
        wdata_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b0);
        end
        tick(2);
        @(negedge wr_clk);
        checkOutput("ovfBefore", {63'h0, overflow}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h7000 + 16'(i), 1'b0);
        end
        void'(expWords.pop_back());
        mPending--;
        tick(2);
        @(negedge wr_clk);
        checkOutput("ovfSet", {63'h0, overflow}, 64'h1);
        wdata_ready = 1'b1;
        waitBeats(64);
        scoreboard();
        tick(40);
        checkOutput("noExtraBeat", 64'(obsBeat.size()), 64'h0);
        @(negedge wr_clk);
        checkOutput("ovfSticky", {63'h0, overflow}, 64'h1);
        applyStimulus(1'b0, 16'h0, 1'b1);
        tick(1);
        @(negedge wr_clk);
        checkOutput("ovfCleared", {63'h0, overflow}, 64'h0);

        // Reset on beat 5 of a burst.
        sendPixels(64, 16'h4000);
        waitBeats(5);
        wr_rst = 1'b1;
        tick(1);
        @(negedge wr_clk);
        checkOutput("midRstReqValid", {63'h0, req_valid}, 64'h0);
        checkOutput("midRstWdValid", {63'h0, wdata_valid}, 64'h0);
        checkOutput("midRstWdata", wdata, 64'h0);
        checkOutput("midRstLast", {63'h0, wdata_last}, 64'h0);
        checkOutput("midRstReqAddr", {36'h0, req_addr}, 64'h0);
        scoreboard();
        expWords.delete();
        expAddr.delete();
        mLane = 0;
        mPending = 0;
        mBurstIdx = 0;
        beatIdx = 0;
        tick(1);
        wr_rst = 1'b0;
        sendPixels(64, 16'h5000);
        waitBeats(16);
        scoreboard();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
